// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared states, widths and clock constants for the period meter
package period_meter_pkg;

   localparam int          DEFAULT_CNT_W = 32;
   localparam int unsigned SYS_CLK_HZ    = 100_000_000;

   // FSM encoding, kept as plain constants so older tools and netlists see fixed codes
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_ARM     = 2'd1;
   localparam state_t ST_MEASURE = 2'd2;
   localparam state_t ST_TMO     = 2'd3;

   // Expected period in system clocks for an input of the given frequency
   function automatic int unsigned cycles_per_period(input int unsigned hz);
      return SYS_CLK_HZ / hz;
   endfunction

endpackage

// File: rtl/period_meter_if.sv
// rtl/period_meter_if.sv - measured waveform, control and result bundle of the period meter
interface period_meter_if
   import period_meter_pkg::*;
#(
   parameter int CNT_W = DEFAULT_CNT_W
);

   logic             sig_in;
   logic             enable;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             valid;
   logic             timeout;
   logic             locked;

   modport master (
      output sig_in, enable,
      input  period, high_time, valid, timeout, locked
   );

   modport slave (
      input  sig_in, enable,
      output period, high_time, valid, timeout, locked
   );

endinterface

// File: rtl/period_meter_sync_edge_detect.sv
// rtl/period_meter_sync_edge_detect.sv - synchronizer chain with rise/fall detection
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic s_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   // shift the asynchronous input through the chain and keep one cycle of history
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign s_o    = sync_q[SYNC_STAGES-1];
   assign rise_o = s_o & ~hist_q;
   assign fall_o = ~s_o & hist_q;

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures period and high time of a slow input in system clocks
module period_meter
   import period_meter_pkg::*;
#(
   parameter int CNT_W       = DEFAULT_CNT_W,
   parameter int TIMEOUT     = 400_000,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         reset,
   period_meter_if.slave pm
);

   logic             rise, fall;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [CNT_W-1:0] hi_q, hi_d;
   logic             hi_seen_q, hi_seen_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;
   logic             locked_q, locked_d;
   logic             tmo_hit;

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .d_i    (pm.sig_in),
      .s_o    (),
      .rise_o (rise),
      .fall_o (fall)
   );

   // counter saturates instead of wrapping so a huge period never reads as a short one
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
   assign tmo_hit = (64'(cnt_q) >= 64'(TIMEOUT));

   // next-state: a rise always beats the timeout check in the same cycle
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      hi_seen_d = hi_seen_q;
      period_d  = period_q;
      high_d    = high_q;
      valid_d   = 1'b0;
      timeout_d = timeout_q;
      locked_d  = locked_q;
      if (!pm.enable) begin
         state_d   = ST_IDLE;
         cnt_d     = '0;
         hi_d      = '0;
         hi_seen_d = 1'b0;
         period_d  = '0;
         high_d    = '0;
         timeout_d = 1'b0;
         locked_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_ARM;
               cnt_d   = '0;
            end
            ST_ARM: begin
               if (rise) begin
                  state_d   = ST_MEASURE;
                  cnt_d     = CNT_W'(1);
                  hi_d      = '0;
                  hi_seen_d = 1'b0;
               end else if (tmo_hit) begin
                  state_d   = ST_TMO;
                  timeout_d = 1'b1;
                  locked_d  = 1'b0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            ST_MEASURE: begin
               if (rise) begin
                  period_d  = cnt_q;
                  high_d    = hi_seen_q ? hi_q : '0;
                  valid_d   = 1'b1;
                  locked_d  = 1'b1;
                  cnt_d     = CNT_W'(1);
                  hi_d      = '0;
                  hi_seen_d = 1'b0;
               end else if (tmo_hit) begin
                  state_d   = ST_TMO;
                  timeout_d = 1'b1;
                  locked_d  = 1'b0;
               end else begin
                  cnt_d = cnt_inc;
                  if (fall && !hi_seen_q) begin
                     hi_d      = cnt_q;
                     hi_seen_d = 1'b1;
                  end
               end
            end
            ST_TMO: begin
               if (rise) begin
                  state_d   = ST_MEASURE;
                  timeout_d = 1'b0;
                  cnt_d     = CNT_W'(1);
                  hi_d      = '0;
                  hi_seen_d = 1'b0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // state and result registers, all cleared by reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         hi_seen_q <= 1'b0;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         hi_seen_q <= hi_seen_d;
         period_q  <= period_d;
         high_q    <= high_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         locked_q  <= locked_d;
      end
   end

   assign pm.period    = period_q;
   assign pm.high_time = high_q;
   assign pm.valid     = valid_q;
   assign pm.timeout   = timeout_q;
   assign pm.locked    = locked_q;

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - randomized and directed checks of period_meter against an edge-list model
`timescale 1ns/1ps
module tb_period_meter;
   import period_meter_pkg::*;

   localparam int CNT_W = 32;
   localparam int TO    = 400;
   localparam int SS    = 2;
   localparam int LAT   = SS + 1;
   // 500 Hz half period, scaled down by 1000 to keep the run short
   localparam int HALF  = int'(cycles_per_period(500)) / 2 / 1000;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   cyc   = 0;

   period_meter_if #(.CNT_W(CNT_W)) pm ();

   period_meter #(.CNT_W(CNT_W), .TIMEOUT(TO), .SYNC_STAGES(SS)) dut (
      .clk   (clk),
      .reset (reset),
      .pm    (pm)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int vec_cnt = 0;
   int err_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // model: a list of expected measurements derived only from the rise/fall times we drive
   typedef struct { int at; int per; int hi; } vexp_t;
   typedef struct { int at; int per; } texp_t;
   vexp_t vq[$];
   texp_t tq[$];
   vexp_t ve;
   texp_t te;
   bit    have_ref   = 1'b0;
   bit    tmo_pushed = 1'b0;
   int    ref_rise   = 0;
   int    ref_fall   = -1;
   int    last_per   = 0;

   task automatic model_clear();
      have_ref   = 1'b0;
      tmo_pushed = 1'b0;
      last_per   = 0;
      ref_fall   = -1;
   endtask

   task automatic model_rise(input int t);
      int gap;
      if (have_ref) begin
         gap = t - ref_rise;
         if (gap <= TO) begin
            vq.push_back('{t + LAT, gap, (ref_fall >= 0) ? ref_fall - ref_rise : 0});
            last_per = gap;
         end else if (!tmo_pushed) begin
            tq.push_back('{ref_rise + LAT + TO, last_per});
         end
      end
      have_ref   = 1'b1;
      ref_rise   = t;
      ref_fall   = -1;
      tmo_pushed = 1'b0;
   endtask

   task automatic drive_level(input logic lvl, input int n);
      if (lvl !== pm.sig_in) begin
         if (lvl) model_rise(cyc);
         else if (have_ref && ref_fall < 0) ref_fall = cyc;
         pm.sig_in = lvl;
      end
      if (have_ref && !tmo_pushed && (cyc + n - ref_rise) > TO) begin
         tq.push_back('{ref_rise + LAT + TO, last_per});
         tmo_pushed = 1'b1;
      end
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int h, input int l);
      drive_level(1'b1, h);
      drive_level(1'b0, l);
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_period"},  pm.period,    0);
      chk({tag, "_high"},    pm.high_time, 0);
      chk({tag, "_valid"},   pm.valid,     0);
      chk({tag, "_timeout"}, pm.timeout,   0);
      chk({tag, "_locked"},  pm.locked,    0);
   endtask

   // monitor: every valid pulse and every timeout onset must match the model in time and value
   bit   mon_en  = 1'b0;
   logic to_prev = 1'b0;
   always @(negedge clk) begin
      if (mon_en) begin
         if (vq.size() > 0 && vq[0].at < cyc) begin
            chk("missed_valid", cyc, vq[0].at);
            ve = vq.pop_front();
         end
         if (tq.size() > 0 && tq[0].at < cyc) begin
            chk("missed_timeout", cyc, tq[0].at);
            te = tq.pop_front();
         end
         if (pm.valid) begin
            if (vq.size() == 0) begin
               chk("unexpected_valid", pm.valid, 0);
            end else begin
               ve = vq.pop_front();
               chk("valid_cycle", cyc, ve.at);
               chk("period", pm.period, ve.per);
               chk("high_time", pm.high_time, ve.hi);
               chk("locked_on_valid", pm.locked, 1);
               chk("timeout_on_valid", pm.timeout, 0);
            end
         end
         if (pm.timeout && !to_prev) begin
            if (tq.size() == 0) begin
               chk("unexpected_timeout", pm.timeout, 0);
            end else begin
               te = tq.pop_front();
               chk("timeout_cycle", cyc, te.at);
               chk("locked_on_timeout", pm.locked, 0);
               chk("period_held", pm.period, te.per);
            end
         end
      end
      to_prev <= pm.timeout;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int h, l;
      pm.sig_in = 1'b0;
      pm.enable = 1'b0;
      reset     = 1'b0;
      repeat (3) @(negedge clk);
      chk_cleared("reset");
      reset = 1'b1;
      @(negedge clk);
      chk_cleared("idle");

      pm.enable = 1'b1;
      mon_en    = 1'b1;
      drive_level(1'b0, 5);

      // 500 Hz 50% duty, scaled
      repeat (6) pulse(HALF, HALF);
      // 25% duty period 8, then the minimum 2+2 case
      repeat (4) pulse(2, 6);
      repeat (4) pulse(2, 2);

      // random shapes, some landing right around the timeout boundary
      repeat (40) begin
         h = $urandom_range(2, 40);
         l = $urandom_range(2, 60);
         if ($urandom_range(0, 7) == 0) begin
            h = $urandom_range(2, 100);
            l = TO - h + $urandom_range(0, 4) - 2;
         end
         pulse(h, l);
      end

      // rise exactly at cnt==TIMEOUT is a measurement; one cycle later is a timeout
      pulse(100, 100);
      pulse(100, TO - 100);
      pulse(100, TO - 99);
      pulse(HALF, HALF);

      // stop the input, then restart it
      repeat (4) pulse(HALF, HALF);
      drive_level(1'b1, HALF);
      drive_level(1'b0, 2 * TO);
      chk("stop_timeout", pm.timeout, 1);
      chk("stop_locked", pm.locked, 0);
      chk("stop_period", pm.period, 2 * HALF);
      repeat (3) pulse(HALF, HALF);

      // reset mid-period while the input is high
      pulse(HALF, HALF);
      drive_level(1'b1, 50);
      reset = 1'b0;
      model_clear();
      @(negedge clk);
      chk_cleared("midreset");
      drive_level(1'b0, 3);
      reset = 1'b1;
      drive_level(1'b0, 10);
      repeat (4) pulse(30, 30);

      // enable dropped for 10 cycles mid-measurement
      pulse(20, 20);
      drive_level(1'b1, 10);
      pm.enable = 1'b0;
      model_clear();
      drive_level(1'b0, 1);
      chk_cleared("disable");
      drive_level(1'b0, 9);
      pm.enable = 1'b1;
      drive_level(1'b0, 5);
      repeat (4) pulse(20, 20);

      drive_level(1'b0, LAT + 5);
      chk("valid_queue_drained", vq.size(), 0);
      chk("timeout_queue_drained", tq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
